paddle_btn_cmd: RTL and testbench

Command generator that converts one player's two raw push-buttons into the 2-bit `btn` move command consumed by the paddle block. It synchronises and debounces both buttons, resolves direction, and rate-limits movement into single-cycle step pulses so the paddle advances at a controlled rate rather than once per clock. The top module instantiates one per player, driving the paddle `btn` input directly.

---
 rtl/paddle_pkg.sv | 16 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/paddle_btn_cmd.sv | 133 +++++++++++++
 tb/tb_paddle_btn_cmd.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared paddle types: the 2-bit move command encoding and the command FSM state.
package paddle_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_DN   = 2'b01,
        DIR_UP   = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StUp   = 2'b01,
        StDown = 2'b10
    } cmd_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw push-button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        // Any sample agreeing with the accepted level restarts the stability count.
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/paddle_btn_cmd.sv
// Converts two raw buttons into rate-limited single-cycle paddle step pulses.
// Define PADDLE_BTN_CMD_ACCEL_EN to halve the repeat period after ACCEL_STEPS pulses.
module paddle_btn_cmd
    import paddle_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MOVE_PERIOD     = 416667,
    parameter int unsigned ACCEL_STEPS     = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up_raw,
    input  logic       btn_dn_raw,
    input  logic       enable,
    output logic [1:0] btn_cmd,
    output logic       held_up,
    output logic       held_dn
);

    localparam int unsigned RateW = $clog2(MOVE_PERIOD);
    localparam logic [RateW-1:0] FullReload = RateW'(MOVE_PERIOD - 1);

    cmd_state_t       state_q, state_d;
    dir_t             cmd_q, cmd_d;
    dir_t             dir;
    cmd_state_t       tgt;
    logic [RateW-1:0] rate_q, rate_d;
    logic             pulse;

`ifdef PADDLE_BTN_CMD_ACCEL_EN
    localparam int unsigned StepW = $clog2(ACCEL_STEPS + 1);
    localparam logic [StepW-1:0] StepMax = StepW'(ACCEL_STEPS);
    localparam logic [RateW-1:0] HalfReload = RateW'((MOVE_PERIOD >> 1) - 1);
    logic [StepW-1:0] step_q, step_d;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk_i  (clk),
        .rst_ni (rst),
        .raw_i  (btn_up_raw),
        .level_o(held_up)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_dn (
        .clk_i  (clk),
        .rst_ni (rst),
        .raw_i  (btn_dn_raw),
        .level_o(held_dn)
    );

    always_comb begin
        if (held_up && !held_dn) begin
            dir = DIR_UP;
        end else if (held_dn && !held_up) begin
            dir = DIR_DN;
        end else begin
            dir = DIR_NONE;
        end
        tgt = (dir == DIR_UP) ? StUp : StDown;
    end

    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        cmd_d   = DIR_NONE;
        pulse   = 1'b0;
`ifdef PADDLE_BTN_CMD_ACCEL_EN
        step_d  = step_q;
`endif
        if (!enable || dir == DIR_NONE) begin
            state_d = StIdle;
            rate_d  = '0;
`ifdef PADDLE_BTN_CMD_ACCEL_EN
            step_d  = '0;
`endif
        end else if (state_q == StIdle) begin
            state_d = tgt;
            pulse   = 1'b1;
        end else if (state_q != tgt) begin
            state_d = tgt;
`ifdef PADDLE_BTN_CMD_ACCEL_EN
            step_d  = '0;
`endif
            // A flip right after a pulse is deferred one cycle so pulses never abut.
            if (cmd_q == DIR_NONE) begin
                pulse = 1'b1;
            end else begin
                rate_d = '0;
            end
        end else if (rate_q == '0) begin
            pulse = 1'b1;
        end else begin
            rate_d = rate_q - 1'b1;
        end

        if (pulse) begin
            cmd_d = dir;
`ifdef PADDLE_BTN_CMD_ACCEL_EN
            if (step_d != StepMax) begin
                step_d = step_d + 1'b1;
            end
            rate_d = (step_d == StepMax) ? HalfReload : FullReload;
`else
            rate_d = FullReload;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cmd_q   <= DIR_NONE;
            rate_q  <= '0;
`ifdef PADDLE_BTN_CMD_ACCEL_EN
            step_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rate_q  <= rate_d;
`ifdef PADDLE_BTN_CMD_ACCEL_EN
            step_q  <= step_d;
`endif
        end
    end

    assign btn_cmd = cmd_q;

endmodule

// File: tb/tb_paddle_btn_cmd.sv
// Randomised and directed bench for paddle_btn_cmd against a timestamp-based reference model.
module tb_paddle_btn_cmd;

    localparam int DB  = 4;
    localparam int MP  = 8;
    localparam int ACC = 3;
`ifdef PADDLE_BTN_CMD_ACCEL_EN
    localparam bit Accel = 1'b1;
`else
    localparam bit Accel = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       btn_up_raw;
    logic       btn_dn_raw;
    logic       enable;
    logic [1:0] btn_cmd;
    logic       held_up;
    logic       held_dn;

    int checks;
    int errors;

    paddle_btn_cmd #(
        .DEBOUNCE_CYCLES(DB),
        .MOVE_PERIOD    (MP),
        .ACCEL_STEPS    (ACC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up_raw(btn_up_raw),
        .btn_dn_raw(btn_dn_raw),
        .enable    (enable),
        .btn_cmd   (btn_cmd),
        .held_up   (held_up),
        .held_dn   (held_dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw sample history, accepted levels, and pulse schedule by cycle number.
    bit         hu_hist[$];
    bit         hd_hist[$];
    bit         m_hu, m_hd;
    logic [1:0] m_cmd;
    int         m_active, m_due, m_steps, cyc;

    task automatic model_reset();
        hu_hist.delete();
        hd_hist.delete();
        for (int i = 0; i < DB + 2; i++) begin
            hu_hist.push_back(1'b0);
            hd_hist.push_back(1'b0);
        end
        m_hu = 0; m_hd = 0; m_cmd = 2'b00;
        m_active = 0; m_due = 0; m_steps = 0;
    endtask

    // Level flips once the last DB synchronised samples all disagree with it.
    task automatic model_edge();
        logic [1:0] dir;
        bit pulse, flip_u, flip_d;
        cyc++;
        hu_hist.push_front(btn_up_raw); void'(hu_hist.pop_back());
        hd_hist.push_front(btn_dn_raw); void'(hd_hist.pop_back());
        dir = (m_hu && !m_hd) ? 2'b10 : (m_hd && !m_hu) ? 2'b01 : 2'b00;
        pulse = 0;
        if (!enable || dir == 2'b00) begin
            m_active = 0; m_steps = 0;
        end else if (int'(dir) != m_active) begin
            m_active = int'(dir); m_steps = 0;
            if (m_cmd == 2'b00) pulse = 1; else m_due = cyc + 1;
        end else if (cyc == m_due) begin
            pulse = 1;
        end
        if (pulse) begin
            if (m_steps < ACC) m_steps++;
            m_due = cyc + ((Accel && m_steps >= ACC) ? MP / 2 : MP);
        end
        m_cmd = pulse ? dir : 2'b00;
        flip_u = 1; flip_d = 1;
        for (int i = 2; i < DB + 2; i++) begin
            if (hu_hist[i] == m_hu) flip_u = 0;
            if (hd_hist[i] == m_hd) flip_d = 0;
        end
        if (flip_u) m_hu = !m_hu;
        if (flip_d) m_hd = !m_hd;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_up_raw = 0; btn_dn_raw = 0; enable = 1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (btn_cmd !== 2'b00) begin errors++; $display("FAIL reset_cmd got %b want 00", btn_cmd); end
        checks++;
        if (held_up !== 1'b0) begin errors++; $display("FAIL reset_held_up got %b want 0", held_up); end
        checks++;
        if (held_dn !== 1'b0) begin errors++; $display("FAIL reset_held_dn got %b want 0", held_dn); end
        do_reset();
    endtask

    task automatic test_hold_up();
        int rise_at, first_at;
        rise_at = -1; first_at = -1;
        btn_up_raw = 1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (held_up === 1'b1 && rise_at < 0) rise_at = k;
            if (btn_cmd !== 2'b00 && first_at < 0) first_at = k;
            checks++;
            if (btn_cmd !== m_cmd) begin errors++; $display("FAIL hold_up_cmd cyc %0d got %b want %b", cyc, btn_cmd, m_cmd); end
            checks++;
            if (btn_cmd === 2'b01) begin errors++; $display("FAIL hold_up_dir cyc %0d got 01 want not 01", cyc); end
        end
        checks++;
        if (rise_at != 2 + DB) begin errors++; $display("FAIL hold_up_rise got %0d want %0d", rise_at, 2 + DB); end
        checks++;
        if (first_at != 3 + DB) begin errors++; $display("FAIL hold_up_first got %0d want %0d", first_at, 3 + DB); end
        btn_up_raw = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (btn_cmd !== m_cmd || held_up !== m_hu) begin
                errors++; $display("FAIL release_up cyc %0d got %b/%b want %b/%b", cyc, btn_cmd, held_up, m_cmd, m_hu);
            end
        end
    endtask

    task automatic test_glitch();
        bit seen;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            btn_up_raw = (k < DB - 1);
            step();
            if (held_up !== 1'b0 || btn_cmd !== 2'b00) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL glitch got activity want held_up=0 btn_cmd=00"); end
    endtask

    task automatic test_both_then_release();
        int first_at;
        first_at = -1;
        btn_up_raw = 1; btn_dn_raw = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (btn_cmd !== 2'b00) begin errors++; $display("FAIL both_cmd cyc %0d got %b want 00", cyc, btn_cmd); end
        end
        btn_up_raw = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (btn_cmd === 2'b01 && first_at < 0) first_at = k;
            checks++;
            if (btn_cmd !== m_cmd) begin errors++; $display("FAIL both_rel cyc %0d got %b want %b", cyc, btn_cmd, m_cmd); end
        end
        checks++;
        if (first_at != 3 + DB) begin errors++; $display("FAIL both_rel_first got %0d want %0d", first_at, 3 + DB); end
        btn_dn_raw = 0;
        repeat (12) step();
    endtask

    task automatic test_switch();
        int first_at;
        first_at = -1;
        btn_up_raw = 1;
        repeat (20) step();
        btn_up_raw = 0; btn_dn_raw = 1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (btn_cmd === 2'b01 && first_at < 0) first_at = k;
            checks++;
            if (btn_cmd !== m_cmd) begin errors++; $display("FAIL switch_cmd cyc %0d got %b want %b", cyc, btn_cmd, m_cmd); end
        end
        checks++;
        if (first_at != 3 + DB) begin errors++; $display("FAIL switch_first got %0d want %0d", first_at, 3 + DB); end
        btn_dn_raw = 0;
        repeat (12) step();
    endtask

    task automatic test_enable_and_reset();
        int first_at;
        btn_up_raw = 1;
        repeat (12) step();
        enable = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            checks++;
            if (btn_cmd !== 2'b00) begin errors++; $display("FAIL enable_low cyc %0d got %b want 00", cyc, btn_cmd); end
        end
        enable = 1;
        step();
        checks++;
        if (btn_cmd !== 2'b10) begin errors++; $display("FAIL enable_restore got %b want 10", btn_cmd); end
        repeat (5) step();
        checks++;
        if (held_up !== 1'b1) begin errors++; $display("FAIL pre_reset_held got %b want 1", held_up); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (btn_cmd !== 2'b00 || held_up !== 1'b0 || held_dn !== 1'b0) begin
            errors++; $display("FAIL async_reset got %b/%b/%b want 00/0/0", btn_cmd, held_up, held_dn);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        first_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (btn_cmd !== 2'b00 && first_at < 0) first_at = k;
        end
        checks++;
        if (first_at != 3 + DB) begin errors++; $display("FAIL post_reset_first got %0d want %0d", first_at, 3 + DB); end
        btn_up_raw = 0;
        repeat (12) step();
    endtask

    task automatic test_spacing();
        int times[$];
        int want;
        btn_dn_raw = 1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (btn_cmd !== 2'b00) times.push_back(k);
        end
        checks++;
        if (times.size() < 6) begin
            errors++; $display("FAIL spacing_count got %0d want >=6", times.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                want = (Accel && i + 1 >= ACC) ? MP / 2 : MP;
                checks++;
                if (times[i+1] - times[i] != want) begin
                    errors++; $display("FAIL spacing_%0d got %0d want %0d", i, times[i+1] - times[i], want);
                end
            end
        end
        btn_dn_raw = 0;
        repeat (12) step();
    endtask

    task automatic test_random();
        logic [1:0] prev;
        int thr;
        prev = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            thr = (i < 750) ? 12 : 5;
            if ($urandom_range(0, thr) == 0) btn_up_raw = ~btn_up_raw;
            if ($urandom_range(0, thr) == 0) btn_dn_raw = ~btn_dn_raw;
            if ($urandom_range(0, 80) == 0) enable = ~enable;
            step();
            checks++;
            if (btn_cmd !== m_cmd) begin errors++; $display("FAIL rand_cmd cyc %0d got %b want %b", cyc, btn_cmd, m_cmd); end
            checks++;
            if (held_up !== m_hu || held_dn !== m_hd) begin
                errors++; $display("FAIL rand_held cyc %0d got %b%b want %b%b", cyc, held_up, held_dn, m_hu, m_hd);
            end
            checks++;
            if (btn_cmd === 2'b11 || (prev != 2'b00 && btn_cmd !== 2'b00)) begin
                errors++; $display("FAIL rand_pulse cyc %0d got %b after %b want single non-11 pulse", cyc, btn_cmd, prev);
            end
            prev = btn_cmd;
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        model_reset();
        test_reset();
        test_hold_up();
        test_glitch();
        test_both_then_release();
        test_switch();
        test_enable_and_reset();
        test_spacing();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
